// File: rtl/gf2_poly_divider_if.sv
// Handshake and operand/result bundle for gf2_poly_divider.
// master drives the request side; slave is the divider.
interface gf2_poly_divider_if #(
   parameter int N = 768,
   parameter int M = 384
);
   logic             start;
   logic [N-1:0]     dividend;
   logic [M:0]       divisor;
   logic             busy;
   logic             done;
   logic             err;
   logic [N-M-1:0]   quotient;
   logic [M-1:0]     remainder;

   modport master (
      output start, dividend, divisor,
      input  busy, done, err, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, err, quotient, remainder
   );
endinterface

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2) long divider: N-bit dividend by monic degree-M divisor.
// Define GF2_DIV_RADIX4_EN to retire two quotient bits per cycle.
module gf2_poly_divider #(
   parameter int N = 768,
   parameter int M = 384
) (
   input  logic               clk,
   input  logic               rst,
   gf2_poly_divider_if.slave  bus
);
   localparam int QW = N - M;
   localparam int CW = $clog2(N - M + 1);
`ifdef GF2_DIV_RADIX4_EN
   localparam int STEP = 2;
   generate
      if ((QW % 2) != 0) begin : g_odd_qw
         $error("gf2_poly_divider: N-M must be even when GF2_DIV_RADIX4_EN is defined");
      end
   endgenerate
`else
   localparam int STEP = 1;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(QW - STEP);
   localparam logic [CW-1:0] CNT_INC  = CW'(STEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic [M-1:0]    dvs_r;
   logic [M-1:0]    rem_work_r;
   logic [QW-1:0]   sr_r;
   logic [QW-1:0]   q_work_r;
   logic [CW-1:0]   cnt_r;
   logic            busy_r;
   logic            done_r;
   logic            err_r;
   logic [QW-1:0]   quot_r;
   logic [M-1:0]    rem_r;

   logic [M-1:0]    rem_nxt_s;
   logic [QW-1:0]   sr_nxt_s;
   logic [QW-1:0]   q_nxt_s;
   logic [M:0]      step1_s;
`ifdef GF2_DIV_RADIX4_EN
   logic [M:0]      step2_s;
`endif

   // One long-division step: bring down bit b, subtract (XOR) the divisor if the
   // leading term is set. Returns {quotient bit, new partial remainder}.
   function automatic logic [M:0] div_step(
      input logic [M-1:0] r,
      input logic         b,
      input logic [M-1:0] d
   );
      logic [M:0] t;
      t = {r, b};
      if (t[M]) begin
         return {1'b1, t[M-1:0] ^ d};
      end else begin
         return {1'b0, t[M-1:0]};
      end
   endfunction

   // Next partial remainder, shift register and quotient for the current RUN cycle
   always_comb begin
      step1_s = div_step(rem_work_r, sr_r[QW-1], dvs_r);
`ifdef GF2_DIV_RADIX4_EN
      step2_s   = div_step(step1_s[M-1:0], sr_r[QW-2], dvs_r);
      rem_nxt_s = step2_s[M-1:0];
      sr_nxt_s  = {sr_r[QW-3:0], 2'b00};
      q_nxt_s   = {q_work_r[QW-3:0], step1_s[M], step2_s[M]};
`else
      rem_nxt_s = step1_s[M-1:0];
      sr_nxt_s  = {sr_r[QW-2:0], 1'b0};
      q_nxt_s   = {q_work_r[QW-2:0], step1_s[M]};
`endif
   end

   // Control FSM with working state and registered result outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         dvs_r      <= {M{1'b0}};
         rem_work_r <= {M{1'b0}};
         sr_r       <= {QW{1'b0}};
         q_work_r   <= {QW{1'b0}};
         cnt_r      <= {CW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         quot_r     <= {QW{1'b0}};
         rem_r      <= {M{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  quot_r <= {QW{1'b0}};
                  rem_r  <= {M{1'b0}};
                  if (bus.divisor[M]) begin
                     state_r    <= RUN;
                     dvs_r      <= bus.divisor[M-1:0];
                     rem_work_r <= bus.dividend[N-1:QW];
                     sr_r       <= bus.dividend[QW-1:0];
                     q_work_r   <= {QW{1'b0}};
                     cnt_r      <= {CW{1'b0}};
                     err_r      <= 1'b0;
                  end else begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                     err_r   <= 1'b1;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               rem_work_r <= rem_nxt_s;
               sr_r       <= sr_nxt_s;
               q_work_r   <= q_nxt_s;
               cnt_r      <= cnt_r + CNT_INC;
               if (cnt_r == LAST_CNT) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  quot_r  <= q_nxt_s;
                  rem_r   <= rem_nxt_s;
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.quotient  = quot_r;
   assign bus.remainder = rem_r;
endmodule
